btb_update_ctrl: RTL
====================

BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning update-queue entries; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk  in  1  clock; all state is updated on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports res_valid_i in 1 / res_ready_o out 1: handshake for resolved-branch records from the backend.
REQ-005 SHALL have ports res_pc_i in 30 (pc[31:2]), res_target_i in 30, res_type_i in 2, res_taken_i in 1: actual branch outcome.
REQ-006 SHALL have ports res_pred_hit_i in 1, res_pred_taken_i in 1, res_pred_target_i in 30: prediction made at fetch.
REQ-007 SHALL have ports redirect_o out 1 and redirect_pc_o out 30: mispredict redirect to fetch.
REQ-008 SHALL have port upd_stall_i in 1: BTB write port busy (init sweep).
REQ-009 SHALL have ports update_o out 1, upd_pc_o out 30, upd_bta_o out 30, upd_type_o out 2: BTB write port (update_i/wpc_i/bta_i/Br_type_i).

Function
REQ-010 SHALL accept a record on a cycle with res_valid_i && res_ready_o.
REQ-011 SHALL drive res_ready_o = !full, from registered occupancy; no bypass when full, even if a pop occurs in the same cycle.
REQ-012 SHALL compute actual_next = res_taken_i ? res_target_i : res_pc_i+1, and pred_next = res_pred_taken_i ? res_pred_target_i : res_pc_i+1, both 30-bit with wrap-around.
REQ-013 SHALL, when an accepted record has actual_next != pred_next, assert redirect_o for exactly one cycle on the next cycle, with redirect_pc_o = actual_next.
REQ-014 SHALL otherwise hold redirect_o at 0; redirect_pc_o holds its last value.
REQ-015 SHALL mark an accepted record "enqueue-eligible" only if res_taken_i=1 (subject to REQ-024).
REQ-016 SHALL store each eligible record as {pc, target, type} in the FIFO.
REQ-017 SHALL coalesce: if the FIFO is non-empty and the eligible pc equals the pc of the most recently enqueued entry still resident, it overwrites that entry's target/type in place without a push.
REQ-018 SHALL NOT coalesce into an entry being popped in the same cycle; that case is a normal push.
REQ-019 SHALL drive update_o = !empty && !upd_stall_i, with upd_* equal to the head entry, and pop the head on every cycle update_o=1.
REQ-020 SHALL have a latency of 1 cycle from accept to update_o (empty FIFO, no stall); a record accepted in cycle N is first visible in cycle N+1.
REQ-021 SHALL allow simultaneous push and pop; occupancy is unchanged and ordering is FIFO.
REQ-022 SHALL drive upd_pc_o, upd_bta_o and upd_type_o to 0 when empty.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, empty the FIFO (pointers and count = 0) and clear the coalesce-valid flag, redirect_o, and redirect_pc_o (to 0); res_ready_o is 1 from the first cycle after reset; any pending redirect is dropped.

Configuration
REQ-024 SHALL support macro BTB_UPDATE_FILTER_EN: when defined, a taken record is eligible only if res_pred_hit_i=0 or res_pred_target_i != res_target_i or res_pred_type differs; without it, every taken record is eligible.
REQ-025 SHALL, with BTB_UPDATE_FILTER_EN defined, compare the stored type against res_type_i only when res_pred_hit_i=1 (input res_pred_type_i, 2 bits, present only under the macro).

Structure
REQ-026 SHALL take br_type_t (2-bit, including _PC_RELATIVE) and upd_entry_t {pc, bta, type} from shared package bpu_pkg.
REQ-027 SHALL instantiate one sub-module, btb_upd_fifo (synchronous FIFO with a tail-overwrite port); the redirect logic and filter stay in btb_update_ctrl.

Verification
REQ-028 SHALL cover: taken, pc=0x100, target=0x200, pred_hit=0, pred_taken=0 -> next cycle redirect_o=1, redirect_pc_o=0x200; update_o=1, upd_pc_o=0x100, upd_bta_o=0x200.
REQ-029 SHALL cover: not-taken, pc=0x40, pred_taken=1, pred_target=0x80 -> redirect_o=1, redirect_pc_o=0x41; no update_o.
REQ-030 SHALL cover: upd_stall_i=1, 4 taken records with distinct pcs, FIFO_DEPTH=4 -> res_ready_o=0 after the 4th; release the stall -> 4 updates in order on consecutive cycles, then res_ready_o=1.
REQ-031 SHALL cover: stall held, two taken records pc=0x10, targets 0x20 then 0x30 -> one entry; after release a single update with bta=0x30.
REQ-032 SHALL cover: filter on, pred_hit=1, pred_target=target=0x55, taken -> no update and no redirect; filter off -> one update.
REQ-033 SHALL cover: rst_n=0 asserted with 3 queued entries -> next cycle update_o=0, res_ready_o=1, redirect_o=0.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared branch-predictor types: branch kinds and the BTB update record
// carried from the resolve stage to the BTB write port.
package bpu_pkg;

  localparam int PC_W = 30;

  typedef enum logic [1:0] {
    BR_CONDITIONAL = 2'd0,
    BR_PC_RELATIVE = 2'd1,
    BR_INDIRECT    = 2'd2,
    BR_RETURN      = 2'd3
  } br_type_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] bta;
    br_type_t        btype;
  } upd_entry_t;

  // Word-aligned fall-through address; wraps at the top of the 30-bit space.
  function automatic logic [PC_W-1:0] pc_seq_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB update records with an extra port that rewrites
// the most recently pushed entry in place (used to coalesce repeat updates).
module btb_upd_fifo
  import bpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  upd_entry_t           push_data_i,
  input  logic                 ovr_i,
  input  upd_entry_t           ovr_data_i,
  input  logic                 pop_i,
  output upd_entry_t           head_o,
  output logic [PC_W-1:0]      tail_pc_o,
  output logic                 tail_vld_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 one_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  upd_entry_t      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tail_vld_q;
  logic [AW-1:0]   tail_idx;
  logic            push_ok, pop_ok;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(FIFO_DEPTH));
  assign one_o      = (cnt_q == CW'(1));
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign tail_idx   = wptr_q - AW'(1);
  assign head_o     = mem_q[rptr_q];
  assign tail_pc_o  = mem_q[tail_idx].pc;
  assign tail_vld_o = tail_vld_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tail_vld_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      // The newest entry stays resident for as long as anything is queued.
      tail_vld_q <= (cnt_d != '0);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end else if (ovr_i) begin
      mem_q[tail_idx] <= ovr_data_i;
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Resolve-stage BTB update controller: mispredict redirect plus a queued,
// coalescing write stream into the BTB. Optional macro BTB_UPDATE_FILTER_EN.
module btb_update_ctrl
  import bpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            res_valid_i,
  output logic            res_ready_o,
  input  logic [29:0]     res_pc_i,
  input  logic [29:0]     res_target_i,
  input  logic [1:0]      res_type_i,
  input  logic            res_taken_i,
  input  logic            res_pred_hit_i,
  input  logic            res_pred_taken_i,
  input  logic [29:0]     res_pred_target_i,
`ifdef BTB_UPDATE_FILTER_EN
  input  logic [1:0]      res_pred_type_i,
`endif
  output logic            redirect_o,
  output logic [29:0]     redirect_pc_o,
  input  logic            upd_stall_i,
  output logic            update_o,
  output logic [29:0]     upd_pc_o,
  output logic [29:0]     upd_bta_o,
  output logic [1:0]      upd_type_o
);

  logic        accept;
  logic [29:0] actual_next, pred_next;
  logic        mispredict, eligible, coalesce, push, pop;
  logic        redirect_q, redirect_d;
  logic [29:0] redirect_pc_q, redirect_pc_d;
  upd_entry_t  new_entry, head;
  logic [29:0] tail_pc;
  logic        tail_vld, empty, full, one;

  assign accept      = res_valid_i && res_ready_o;
  assign actual_next = res_taken_i      ? res_target_i      : pc_seq_next(res_pc_i);
  assign pred_next   = res_pred_taken_i ? res_pred_target_i : pc_seq_next(res_pc_i);
  assign mispredict  = (actual_next != pred_next);

`ifdef BTB_UPDATE_FILTER_EN
  // Skip writes that would rewrite a BTB entry with identical contents.
  assign eligible = res_taken_i &&
                    (!res_pred_hit_i || (res_pred_target_i != res_target_i) ||
                     (res_pred_type_i != res_type_i));
`else
  logic unused_pred_hit;
  assign unused_pred_hit = res_pred_hit_i;
  assign eligible        = res_taken_i;
`endif

  assign new_entry = '{pc: res_pc_i, bta: res_target_i, btype: br_type_t'(res_type_i)};

  // An entry about to leave through the write port cannot absorb a new record.
  assign coalesce = accept && eligible && tail_vld && (tail_pc == res_pc_i) && !(pop && one);
  assign push     = accept && eligible && !coalesce;
  assign pop      = !empty && !upd_stall_i;

  assign res_ready_o = !full;
  assign update_o    = pop;
  assign upd_pc_o    = empty ? '0 : head.pc;
  assign upd_bta_o   = empty ? '0 : head.bta;
  assign upd_type_o  = empty ? '0 : head.btype;

  btb_upd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (new_entry),
    .ovr_i       (coalesce),
    .ovr_data_i  (new_entry),
    .pop_i       (pop),
    .head_o      (head),
    .tail_pc_o   (tail_pc),
    .tail_vld_o  (tail_vld),
    .empty_o     (empty),
    .full_o      (full),
    .one_o       (one)
  );

  always_comb begin
    redirect_d    = accept && mispredict;
    redirect_pc_d = redirect_pc_q;
    if (accept && mispredict) redirect_pc_d = actual_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

endmodule
